bram_word_writer: RTL and testbench

Fills an inferred simple-dual-port block RAM with data words delivered over a valid/ready stream, for downstream readers such as the unique-value counter. It is the writer end of the BRAM path: a small FSM arms on a start pulse, stores accepted words at consecutive addresses from 0, and stops on a last-word marker or when the RAM is full. It reports the word count and a done pulse. A registered read port is exposed so the reader can scan the contents in place.

---
 rtl/bram_io_pkg.sv | 19 +
 rtl/sdp_bram.sv | 36 +++
 rtl/bram_word_writer.sv | 103 ++++++++++
 tb/tb_bram_word_writer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_io_pkg.sv
// Shared types and width helpers for the BRAM writer/reader path.
package bram_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } wr_state_t;

  // Address width never drops below one bit, even for a single-word RAM.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple-dual-port RAM: one write port, one registered read-first read port.
module sdp_bram
  import bram_io_pkg::*;
#(
  parameter int DEPTH = 19,
  parameter int WIDTH = 32,
  localparam int AW = addr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array has no reset so the tool can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of the array gives read-first behaviour on collisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bram_word_writer.sv
// Stream-to-BRAM writer: arms on start_in, stores words from address 0 until
// in_last or a full RAM, then pulses done_out.
module bram_word_writer
  import bram_io_pkg::*;
#(
  parameter int NUM_DATA_BITS = 32,
  parameter int NUM_RAM_WORDS = 19,
  localparam int AW = addr_bits(NUM_RAM_WORDS),
  localparam int CW = count_bits(NUM_RAM_WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_in,
  input  logic [NUM_DATA_BITS-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic [AW-1:0]            rd_addr_in,
  output logic [NUM_DATA_BITS-1:0] rd_data_out,
  output logic [CW-1:0]            words_written_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [1:0]               state_out
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready does not depend on in_valid, and a start_in in the same cycle
  // cancels the transfer.

  wr_state_t     state, state_next;
  logic [AW-1:0] addr;
  logic [CW-1:0] count;
  logic          transfer;
  logic          restart;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    transfer   = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_next = FILL;
          restart    = 1'b1;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        busy_out = 1'b1;
        if (start_in) begin
          restart = 1'b1;
        end else if (in_valid) begin
          transfer = 1'b1;
          if (in_last || count == CW'(NUM_RAM_WORDS - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      addr  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (restart) begin
        addr  <= '0;
        count <= '0;
      end else if (transfer) begin
        addr  <= addr + AW'(1);
        count <= count + CW'(1);
      end
    end
  end

  assign words_written_out = count;
  assign state_out         = state;

  sdp_bram #(
    .DEPTH (NUM_RAM_WORDS),
    .WIDTH (NUM_DATA_BITS)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (transfer),
    .wr_addr (addr),
    .wr_data (in_data),
    .rd_addr (rd_addr_in),
    .rd_data (rd_data_out)
  );

endmodule

// File: tb/tb_bram_word_writer.sv
// Directed bench for bram_word_writer: vector table plus multi-cycle sequences.
module tb_bram_word_writer;
  import bram_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_in = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [4:0]  rd_addr_in = '0;
  logic [31:0] rd_data_out;
  logic [4:0]  words_written_out;
  logic        busy_out;
  logic        done_out;
  logic [1:0]  state_out;

  int n_checks = 0;
  int n_fail = 0;

  bram_word_writer #(
    .NUM_DATA_BITS (32),
    .NUM_RAM_WORDS (19)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start_in          (start_in),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .rd_addr_in        (rd_addr_in),
    .rd_data_out       (rd_data_out),
    .words_written_out (words_written_out),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .state_out         (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic [4:0]  rd_addr;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_done;
    logic [4:0]  exp_count;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] d,
                       input logic l, input logic [4:0] ra);
    start_in = s;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    rd_addr_in = ra;
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b0, '0, 1'b0, a);
    tick();
    chk(name, rd_data_out, exp);
  endtask

  initial begin
    int accepted;
    bit seen_full;

    // Five-word fill with in_last, then start in DONE (ignored), in_last in IDLE, readback.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h11, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h22, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h33, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h44, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h55, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h11};
    vecs[7]  = '{1'b0, 1'b1, 32'h99, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h22};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h33};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h44};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h55};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h11};

    // Reset for three cycles.
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_count", 32'(words_written_out), 32'd0);
    chk("rst_rd", rd_data_out, 32'd0);
    chk("rst_state", 32'(state_out), 32'(IDLE));

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].start, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].rd_addr);
      tick();
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("v%0d_busy", i), 32'(busy_out), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done", i), 32'(done_out), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_count", i), 32'(words_written_out), 32'(vecs[i].exp_count));
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rd", i), rd_data_out, vecs[i].exp_rd);
    end

    // Full fill: 25 offered words, only 19 accepted.
    drive(1'b1, 1'b0, '0, 1'b0, 5'd0);
    tick();
    accepted = 0;
    seen_full = 0;
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b1, 32'h100 + i, 1'b0, 5'd0);
      if (in_ready) accepted++;
      tick();
      if (accepted == 19 && !seen_full) begin
        seen_full = 1;
        chk("full_ready_fall", 32'(in_ready), 32'd0);
        chk("full_done", 32'(done_out), 32'd1);
        chk("full_count", 32'(words_written_out), 32'd19);
      end
    end
    chk("full_accepted", 32'(accepted), 32'd19);
    chk("full_seen", 32'(seen_full), 32'd1);
    chk("full_count_hold", 32'(words_written_out), 32'd19);
    read_chk("full_rd18", 5'd18, 32'h112);
    read_chk("full_rd0", 5'd0, 32'h100);

    // Sparse valid with read of the address being written: read-first, then new word.
    drive(1'b1, 1'b0, '0, 1'b0, 5'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 32'hA0 + k, (k == 3), 5'(k));
      tick();
      chk($sformatf("tog%0d_old", k), rd_data_out, 32'h100 + k);
      chk($sformatf("tog%0d_count", k), 32'(words_written_out), 32'(k + 1));
      if (k == 3) chk("tog_done", 32'(done_out), 32'd1);
      drive(1'b0, 1'b0, '0, 1'b0, 5'(k));
      tick();
      chk($sformatf("tog%0d_new", k), rd_data_out, 32'hA0 + k);
    end

    // Restart mid-fill: transfer in the start cycle is discarded.
    drive(1'b1, 1'b0, '0, 1'b0, 5'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'hC0 + k, 1'b0, 5'd0);
      tick();
    end
    chk("rs_count3", 32'(words_written_out), 32'd3);
    drive(1'b1, 1'b1, 32'hEE, 1'b0, 5'd0);
    tick();
    chk("rs_count0", 32'(words_written_out), 32'd0);
    chk("rs_busy", 32'(busy_out), 32'd1);
    drive(1'b0, 1'b1, 32'hD0, 1'b1, 5'd0);
    tick();
    chk("rs_count1", 32'(words_written_out), 32'd1);
    chk("rs_done", 32'(done_out), 32'd1);
    read_chk("rs_rd0", 5'd0, 32'hD0);
    read_chk("rs_rd1", 5'd1, 32'hC1);
    read_chk("rs_rd3", 5'd3, 32'hA3);

    // Reset mid-fill: outputs return to reset values, RAM keeps its words.
    drive(1'b1, 1'b0, '0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 32'h51, 1'b0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 32'h52, 1'b0, 5'd0);
    tick();
    chk("mr_count2", 32'(words_written_out), 32'd2);
    drive(1'b0, 1'b0, '0, 1'b0, 5'd0);
    reset = 1'b0;
    tick();
    chk("mr_state", 32'(state_out), 32'(IDLE));
    chk("mr_ready", 32'(in_ready), 32'd0);
    chk("mr_busy", 32'(busy_out), 32'd0);
    chk("mr_done", 32'(done_out), 32'd0);
    chk("mr_count", 32'(words_written_out), 32'd0);
    chk("mr_rd", rd_data_out, 32'd0);
    reset = 1'b1;
    read_chk("mr_rd0", 5'd0, 32'h51);
    read_chk("mr_rd1", 5'd1, 32'h52);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
